unidad_control_pila: RTL and testbench

- Multi-cycle control unit for the microcontroller datapath; successor to the single-cycle opcode decoder.
- Registers each opcode in a FETCH cycle and drives ALU, register-file, flag and PC controls in an EXEC cycle.
- Adds conditional jumps on the zero flag, call/return via an internal parametrised return-address stack, a halt state and a sticky error state.

---
 rtl/unidad_control_pila_if.sv | 40 ++++
 rtl/unidad_control_pila.sv | 170 +++++++++++++++++
 tb/tb_unidad_control_pila.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/unidad_control_pila_if.sv
// Bus between the multi-cycle control unit and the datapath.
// Macro IRQ_EN adds the irq / irq_ack pair.
interface unidad_control_pila_if #(
  parameter int AW = 10
);
  logic [5:0]    opcode;
  logic          zero;
  logic [AW-1:0] pc_next;
  logic          s_inm;
  logic          we3;
  logic          wez;
  logic [2:0]    op;
  logic          pc_we;
  logic [1:0]    pc_sel;
  logic [AW-1:0] ret_addr;
  logic          halted;
  logic          err;
`ifdef IRQ_EN
  logic          irq;
  logic          irq_ack;

  modport master (
    output opcode, zero, pc_next, irq,
    input  s_inm, we3, wez, op, pc_we, pc_sel, ret_addr, halted, err, irq_ack
  );
  modport slave (
    input  opcode, zero, pc_next, irq,
    output s_inm, we3, wez, op, pc_we, pc_sel, ret_addr, halted, err, irq_ack
  );
`else
  modport master (
    output opcode, zero, pc_next,
    input  s_inm, we3, wez, op, pc_we, pc_sel, ret_addr, halted, err
  );
  modport slave (
    input  opcode, zero, pc_next,
    output s_inm, we3, wez, op, pc_we, pc_sel, ret_addr, halted, err
  );
`endif
endinterface

// File: rtl/unidad_control_pila.sv
// Two-cycle (FETCH/EXEC) control unit with zero-flag jumps, call/return stack, HALT and sticky ERROR.
// Macro IRQ_EN enables a single-level interrupt entry (IRQ_ACK state) and the reti opcode.
module unidad_control_pila #(
  parameter int            AW      = 10,
  parameter int            DEPTH   = 4,
  parameter logic [AW-1:0] IRQ_VEC = '0
) (
  input  logic                  i_reloj,
  input  logic                  i_reset,
  unidad_control_pila_if.slave  io_bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_FETCH, ST_EXEC, ST_HALT, ST_ERROR, ST_IRQ_ACK
  } estado_t;

  estado_t       r_estado;
  logic [5:0]    r_ir;
  logic [SPW-1:0] r_sp;
  logic          r_err;
  logic [AW-1:0] r_pila [DEPTH];

  logic          w_lleno, w_vacio, w_push, w_pop, w_fallo, w_halt;
  logic [IW-1:0] w_idx_top, w_idx_push;
`ifdef IRQ_EN
  logic          r_in_isr;
  logic          w_reti;
`endif

  assign w_lleno    = (r_sp == SPW'(DEPTH));
  assign w_vacio    = (r_sp == '0);
  assign w_idx_top  = IW'(r_sp - SPW'(1));
  assign w_idx_push = IW'(r_sp);

  assign io_bus.ret_addr = w_vacio ? '0 : r_pila[w_idx_top];
  assign io_bus.halted   = (r_estado == ST_HALT);
  assign io_bus.err      = r_err;

  // Decode is combinational from the latched ir and the live zero flag, gated by state.
  always_comb begin
    io_bus.s_inm  = 1'b0;
    io_bus.we3    = 1'b0;
    io_bus.wez    = 1'b0;
    io_bus.op     = 3'b000;
    io_bus.pc_we  = 1'b0;
    io_bus.pc_sel = 2'b00;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_fallo       = 1'b0;
    w_halt        = 1'b0;
`ifdef IRQ_EN
    io_bus.irq_ack = 1'b0;
    w_reti         = 1'b0;
`endif
    if (r_estado == ST_EXEC) begin
      io_bus.pc_we = 1'b1;
      casez (r_ir)
        6'b00????: begin
          io_bus.s_inm = 1'b1;
          io_bus.wez   = 1'b1;
          case (r_ir[3:2])
            2'b00:   begin io_bus.op = 3'b000; io_bus.we3 = 1'b1; end
            2'b01:   begin io_bus.op = 3'b010; io_bus.we3 = 1'b1; end
            2'b10:   io_bus.op = 3'b011;
            default: begin io_bus.op = 3'b110; io_bus.we3 = 1'b1; end
          endcase
        end
        6'b01????, 6'b10????: begin
          io_bus.we3 = 1'b1;
          io_bus.wez = 1'b1;
          io_bus.op  = 3'(r_ir[5:2] - 4'd4);
        end
        6'b110000: io_bus.pc_sel = 2'b01;
        6'b110001: io_bus.pc_sel = io_bus.zero ? 2'b01 : 2'b00;
        6'b110010: io_bus.pc_sel = io_bus.zero ? 2'b00 : 2'b01;
        6'b110011: begin
          io_bus.pc_sel = 2'b01;
          if (w_lleno) begin
            io_bus.pc_we = 1'b0;
            w_fallo      = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
`ifdef IRQ_EN
        6'b111000, 6'b111001: begin
          w_reti = r_ir[0];
`else
        6'b111000: begin
`endif
          io_bus.pc_sel = 2'b10;
          if (w_vacio) begin
            io_bus.pc_we = 1'b0;
            w_fallo      = 1'b1;
          end else begin
            w_pop = 1'b1;
          end
        end
        6'b111111: begin
          io_bus.pc_we = 1'b0;
          w_halt       = 1'b1;
        end
        default: ;
      endcase
    end
`ifdef IRQ_EN
    else if (r_estado == ST_IRQ_ACK) begin
      io_bus.pc_we   = 1'b1;
      io_bus.pc_sel  = 2'b11;
      io_bus.irq_ack = 1'b1;
      w_push         = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_reloj or posedge i_reset) begin
    if (i_reset) begin
      r_estado <= ST_FETCH;
      r_ir     <= '0;
      r_sp     <= '0;
      r_err    <= 1'b0;
`ifdef IRQ_EN
      r_in_isr <= 1'b0;
`endif
    end else begin
      case (r_estado)
        ST_FETCH: begin
`ifdef IRQ_EN
          if (io_bus.irq && !r_in_isr && !w_lleno) r_estado <= ST_IRQ_ACK;
          else
`endif
          begin
            r_ir     <= io_bus.opcode;
            r_estado <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_fallo) begin
            r_err    <= 1'b1;
            r_estado <= ST_ERROR;
          end else if (w_halt) begin
            r_estado <= ST_HALT;
          end else begin
            r_estado <= ST_FETCH;
            if (w_push) r_sp <= r_sp + SPW'(1);
            if (w_pop)  r_sp <= r_sp - SPW'(1);
`ifdef IRQ_EN
            if (w_reti) r_in_isr <= 1'b0;
`endif
          end
        end
`ifdef IRQ_EN
        ST_IRQ_ACK: begin
          r_sp     <= r_sp + SPW'(1);
          r_in_isr <= 1'b1;
          r_estado <= ST_FETCH;
        end
`endif
        default: r_estado <= r_estado;
      endcase
    end
  end

  // Entries are never cleared; the stack pointer alone decides what is live.
  always_ff @(posedge i_reloj) begin
    if (w_push) r_pila[w_idx_push] <= io_bus.pc_next;
  end
endmodule

// File: tb/tb_unidad_control_pila.sv
// Scoreboard bench for unidad_control_pila: stimulus queues expected output vectors tagged
// with the cycle they belong to; a negedge monitor pops and compares them.
module tb_unidad_control_pila;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unidad_control_pila_if #(.AW(10)) bus ();

  unidad_control_pila #(.AW(10), .DEPTH(4), .IRQ_VEC(10'h3F0)) dut (
    .i_reloj (clk),
    .i_reset (rst),
    .io_bus  (bus.slave)
  );

  // {s_inm, we3, wez, op[2:0], pc_we, pc_sel[1:0], halted, err, irq_ack, ret_addr[9:0]}
  typedef struct {
    int unsigned cyc;
    logic [21:0] v;
    string       name;
  } exp_t;
  exp_t q[$];

  function automatic logic [21:0] mk(input logic si, input logic w3, input logic wz,
                                     input logic [2:0] o, input logic pwe, input logic [1:0] ps,
                                     input logic h, input logic e, input logic ack,
                                     input logic [9:0] ra);
    return {si, w3, wz, o, pwe, ps, h, e, ack, ra};
  endfunction

  function automatic logic [21:0] dut_vec();
    logic ack;
`ifdef IRQ_EN
    ack = bus.irq_ack;
`else
    ack = 1'b0;
`endif
    return {bus.s_inm, bus.we3, bus.wez, bus.op, bus.pc_we, bus.pc_sel,
            bus.halted, bus.err, ack, bus.ret_addr};
  endfunction

  task automatic expect_now(input logic [21:0] v, input string nm);
    exp_t e;
    e.cyc = cyc; e.v = v; e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: every negedge, compare all expectations tagged for the current cycle.
  initial begin
    exp_t e;
    logic [21:0] got;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        got = dut_vec();
        n_checks++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
        end else if (got !== e.v) begin
          n_fail++;
          $display("FAIL %s: cycle %0d got %06h expected %06h", e.name, cyc, got, e.v);
        end else begin
          $display("check %s: cycle %0d value %06h ok", e.name, cyc, got);
        end
      end
    end
  end

  // One instruction: FETCH cycle (all enables 0) then EXEC cycle with the given vector.
  task automatic exec(input logic [5:0] opc, input logic z, input logic [9:0] pn,
                      input logic [21:0] ev, input string nm);
    logic [9:0] ra;
    ra = ev[9:0];
    bus.opcode = opc; bus.zero = z; bus.pc_next = pn;
    expect_now(mk(0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, ra), {nm, "_fetch"});
    @(posedge clk); #1;
    expect_now(ev, nm);
    @(posedge clk); #1;
  endtask

  // A cycle in a terminal state: drive an opcode, expect a fixed vector.
  task automatic hold(input logic [5:0] opc, input logic [21:0] ev, input string nm);
    bus.opcode = opc;
    expect_now(ev, nm);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.opcode = 6'd0; bus.zero = 1'b0; bus.pc_next = 10'd0;
`ifdef IRQ_EN
    bus.irq = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted mid-EXEC of 010000 clears outputs before the next edge.
    bus.opcode = 6'b010000;
    expect_now(mk(0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 10'h000), "reset_fetch");
    @(posedge clk); #1;
    rst = 1'b1;
    expect_now(mk(0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 10'h000), "reset_mid_exec");
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU-immediate and ALU-register classes
    exec(6'b000100, 0, 10'h000, mk(1, 1, 1, 3'b010, 1, 2'b00, 0, 0, 0, 10'h000), "alui_010");
    exec(6'b000011, 0, 10'h000, mk(1, 1, 1, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "alui_000");
    exec(6'b001010, 0, 10'h000, mk(1, 0, 1, 3'b011, 1, 2'b00, 0, 0, 0, 10'h000), "alui_cmp");
    exec(6'b001101, 0, 10'h000, mk(1, 1, 1, 3'b110, 1, 2'b00, 0, 0, 0, 10'h000), "alui_110");
    exec(6'b010000, 0, 10'h000, mk(0, 1, 1, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "alur_0");
    exec(6'b011100, 0, 10'h000, mk(0, 1, 1, 3'b011, 1, 2'b00, 0, 0, 0, 10'h000), "alur_3");
    exec(6'b101111, 0, 10'h000, mk(0, 1, 1, 3'b111, 1, 2'b00, 0, 0, 0, 10'h000), "alur_7");

    // Jumps
    exec(6'b110000, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h000), "jump");
    exec(6'b110001, 1, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h000), "jz_z1");
    exec(6'b110001, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "jz_z0");
    exec(6'b110010, 1, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "jnz_z1");
    exec(6'b110010, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h000), "jnz_z0");
    exec(6'b110100, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "nop");
`ifndef IRQ_EN
    exec(6'b111001, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "nop_reti");
`endif

    // Four calls, four returns
    exec(6'b110011, 0, 10'h011, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h000), "call1");
    exec(6'b110011, 0, 10'h022, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h011), "call2");
    exec(6'b110011, 0, 10'h033, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h022), "call3");
    exec(6'b110011, 0, 10'h044, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h033), "call4");
    exec(6'b111000, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b10, 0, 0, 0, 10'h044), "ret1");
    exec(6'b111000, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b10, 0, 0, 0, 10'h033), "ret2");
    exec(6'b111000, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b10, 0, 0, 0, 10'h022), "ret3");
    exec(6'b111000, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b10, 0, 0, 0, 10'h011), "ret4");
    exec(6'b110100, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "nop_empty");

`ifdef IRQ_EN
    // Interrupt entry with pc_next=0x055, then reti
    bus.irq = 1'b1; bus.pc_next = 10'h055; bus.opcode = 6'b000100;
    expect_now(mk(0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 10'h000), "irq_fetch");
    @(posedge clk); #1;
    expect_now(mk(0, 0, 0, 3'b000, 1, 2'b11, 0, 0, 1, 10'h000), "irq_ack");
    @(posedge clk); #1;
    exec(6'b110100, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 10'h055), "isr_nop");
    bus.irq = 1'b0;
    exec(6'b111001, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b10, 0, 0, 0, 10'h055), "reti");
    exec(6'b110100, 0, 10'h000, mk(0, 0, 0, 3'b000, 1, 2'b00, 0, 0, 0, 10'h000), "post_reti");
`endif

    // Halt: 20 cycles of nothing regardless of opcode
    exec(6'b111111, 0, 10'h000, mk(0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 10'h000), "halt");
    for (int i = 0; i < 20; i++)
      hold(6'((i * 13 + 4) % 64), mk(0, 0, 0, 3'b000, 0, 2'b00, 1, 0, 0, 10'h000), "halted");
    do_reset();

    // Return on empty stack
    exec(6'b111000, 0, 10'h000, mk(0, 0, 0, 3'b000, 0, 2'b10, 0, 0, 0, 10'h000), "ret_empty");
    for (int i = 0; i < 3; i++)
      hold(6'b110011, mk(0, 0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 10'h000), "err_empty");
    do_reset();

    // Overflow on the fifth call
    exec(6'b110011, 0, 10'h011, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h000), "fcall1");
    exec(6'b110011, 0, 10'h022, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h011), "fcall2");
    exec(6'b110011, 0, 10'h033, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h022), "fcall3");
    exec(6'b110011, 0, 10'h044, mk(0, 0, 0, 3'b000, 1, 2'b01, 0, 0, 0, 10'h033), "fcall4");
    exec(6'b110011, 0, 10'h0AA, mk(0, 0, 0, 3'b000, 0, 2'b01, 0, 0, 0, 10'h044), "call_full");
    for (int i = 0; i < 3; i++)
      hold(6'b111000, mk(0, 0, 0, 3'b000, 0, 2'b00, 0, 1, 0, 10'h044), "err_full");
    do_reset();
    exec(6'b000100, 0, 10'h000, mk(1, 1, 1, 3'b010, 1, 2'b00, 0, 0, 0, 10'h000), "after_reset");

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
